// File: rtl/store_data_read_arbiter.sv
// Store-data register-file read port arbiter: oldest-first with starvation override.
// Optional perf counter output enabled by defining STDATA_ARB_PERF_EN.
module store_data_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SQN_W     = 7,
  parameter int TAG_W     = 7,
  parameter int OFFS_W    = 2,
  parameter int AGE_LIMIT = 8,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(AGE_LIMIT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        IN_reqValid,
  input  logic [NUM_REQ*TAG_W-1:0]  IN_reqTag,
  input  logic [NUM_REQ*SQN_W-1:0]  IN_reqSqN,
  input  logic [NUM_REQ*OFFS_W-1:0] IN_reqOffs,
  output logic [NUM_REQ-1:0]        OUT_reqReady,
  input  logic                      IN_branchTaken,
  input  logic                      IN_branchFlush,
  input  logic [SQN_W-1:0]          IN_branchSqN,
  input  logic                      IN_ready,
  output logic                      OUT_valid,
  output logic [TAG_W-1:0]          OUT_tag,
  output logic [SQN_W-1:0]          OUT_sqN,
  output logic [OFFS_W-1:0]         OUT_offs,
  output logic [SRC_W-1:0]          OUT_src
`ifdef STDATA_ARB_PERF_EN
  ,
  output logic [31:0]               OUT_perfConflicts
`endif
);

  function automatic logic older(
    input logic [SQN_W-1:0] a,
    input logic [SQN_W-1:0] b
  );
    logic [SQN_W-1:0] d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  logic [SQN_W-1:0]  reqSqN  [NUM_REQ];
  logic [TAG_W-1:0]  reqTag  [NUM_REQ];
  logic [OFFS_W-1:0] reqOffs [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqSqN[i]  = IN_reqSqN[i*SQN_W +: SQN_W];
      reqTag[i]  = IN_reqTag[i*TAG_W +: TAG_W];
      reqOffs[i] = IN_reqOffs[i*OFFS_W +: OFFS_W];
    end
  end

  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [SQN_W-1:0]    sqn_q, sqn_d;
  logic [OFFS_W-1:0]   offs_q, offs_d;
  logic [SRC_W-1:0]    src_q, src_d;

  logic                free;
  logic                grantEn;
  logic                grant;
  logic [NUM_REQ-1:0]  starveHit;
  logic                anyStarve;
  logic                winFound;
  logic [SRC_W-1:0]    winIdx;
  logic [SQN_W-1:0]    bestSqN;

  assign free    = !valid_q || IN_ready;
  assign grantEn = free && !IN_branchTaken && rst;

  // Starved requesters preempt age order; lowest index first.
  always_comb begin
    starveHit = '0;
    winFound  = 1'b0;
    winIdx    = '0;
    bestSqN   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starveHit[i] = IN_reqValid[i] &&
                     (cnt_q[i] >= CNT_W'(AGE_LIMIT));
    end
    anyStarve = |starveHit;
    if (anyStarve) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (starveHit[i] && !winFound) begin
          winFound = 1'b1;
          winIdx   = SRC_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IN_reqValid[i] &&
            (!winFound || older(reqSqN[i], bestSqN))) begin
          winFound = 1'b1;
          winIdx   = SRC_W'(i);
          bestSqN  = reqSqN[i];
        end
      end
    end
  end

  assign grant = grantEn && winFound;

  always_comb begin
    OUT_reqReady = '0;
    if (grant) begin
      OUT_reqReady = NUM_REQ'(1) << winIdx;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (IN_branchTaken || !IN_reqValid[i]) begin
        cnt_d[i] = '0;
      end else if (grantEn) begin
        if (grant && (winIdx == SRC_W'(i))) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] < CNT_W'(AGE_LIMIT)) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [SQN_W-1:0] bDiff;
  logic             bYounger;

  assign bDiff    = sqn_q - IN_branchSqN;
  assign bYounger = !bDiff[SQN_W-1] && (bDiff != '0);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    sqn_d   = sqn_q;
    offs_d  = offs_q;
    src_d   = src_q;
    if (grant) begin
      valid_d = 1'b1;
      tag_d   = reqTag[winIdx];
      sqn_d   = reqSqN[winIdx];
      offs_d  = reqOffs[winIdx];
      src_d   = winIdx;
    end else if (IN_branchTaken) begin
      if (IN_branchFlush || IN_ready || bYounger) begin
        valid_d = 1'b0;
      end
    end else if (IN_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      sqn_q   <= '0;
      offs_q  <= '0;
      src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      sqn_q   <= sqn_d;
      offs_q  <= offs_d;
      src_q   <= src_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign OUT_valid = valid_q;
  assign OUT_tag   = tag_q;
  assign OUT_sqN   = sqn_q;
  assign OUT_offs  = offs_q;
  assign OUT_src   = src_q;

`ifdef STDATA_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        multiReq;
  logic        stallReq;

  assign multiReq = grantEn && ($countones(IN_reqValid) > 1);
  assign stallReq = !free && (|IN_reqValid);

  always_comb begin
    perf_d = perf_q + 32'(multiReq) + 32'(stallReq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign OUT_perfConflicts = perf_q;
`endif

endmodule
